calendar_carry_ctrl: RTL and testbench
======================================

// Module: calendar_carry_ctrl
// PURPOSE
//   Sequences the day/month/year counters of the century clock. In RUN it turns
//   the end-of-day tick into registered increment/clear pulses, with
//   month-length and leap-year rollover. In SET mode a button FSM selects
//   year, then month, then day, and steps the selected field with wrap.
//   Sits between the time-of-day chain and the date counters.
// PARAMETERS
//   YEAR_W    7    width of year input (years 00..99 of the century)
//   YEAR_MAX  99   last year value; clr_year is issued instead of inc_year here
// PORTS
//   clk        in   1       system clock
//   rst        in   1       synchronous reset, active-high
//   day_tick   in   1       1-cycle pulse, end of day (from hour counter carry)
//   mode_btn   in   1       1-cycle debounced pulse, advance set-mode state
//   inc_btn    in   1       1-cycle debounced pulse, step selected field
//   day        in   5       current day, 1..31
//   month      in   4       current month, 1..12
//   year       in   YEAR_W  current year, 0..YEAR_MAX
//   inc_day    out  1       day counter +1
//   clr_day    out  1       day counter load 1
//   inc_month  out  1       month counter +1
//   clr_month  out  1       month counter load 1
//   inc_year   out  1       year counter +1
//   clr_year   out  1       year counter load 0
//   field_sel  out  2       0 none, 1 year, 2 month, 3 day (display blink select)
//   overrun    out  1       sticky: day_tick arrived inside guard window
// BEHAVIOUR
//   - All outputs are registered; rst forces every output to 0 and the state to RUN.
//   - Pulse outputs are high for exactly 1 cycle. Latency is 1 cycle from the
//     triggering input pulse.
//   - dim = days in month. 31 for months 1,3,5,7,8,10,12. 30 for 4,6,9,11.
//     Feb = 29 if year[1:0]==0 (year 00 counts as leap), else 28.
//   - FSM: RUN -mode-> SET_YEAR -mode-> SET_MONTH -mode-> SET_DAY -mode-> RUN.
//     field_sel follows the state: RUN=0, SET_YEAR=1, SET_MONTH=2, SET_DAY=3.
//   - RUN, day_tick, day<dim: inc_day.
//   - RUN, day_tick, day==dim: clr_day plus month action. Month action is
//     inc_month if month<12. If month==12 it is clr_month plus inc_year, or
//     clr_month plus clr_year when year==YEAR_MAX.
//   - Guard window: after an accepted tick, further day_ticks are ignored for
//     2 cycles so the counters can settle. An ignored tick sets overrun, which
//     is cleared only by rst.
//   - SET_*: day_tick is ignored and does not set overrun.
//   - SET_*, inc_btn: step the selected field.
//       SET_YEAR:  inc_year, or clr_year at YEAR_MAX.
//       SET_MONTH: inc_month, or clr_month at 12.
//       SET_DAY:   inc_day, or clr_day at dim.
//     The same 2-cycle guard applies; an inc_btn inside the window is dropped
//     silently.
//   - mode_btn and inc_btn in the same cycle: mode wins and inc is dropped.
//   - Leaving SET_DAY to RUN with day>dim (e.g. Feb 30 left by a month/year
//     change): issue clr_day on the transition cycle.
//   - Out-of-range inputs (month 0 or >12, day 0): treat dim=31. In RUN the
//     next tick issues clr_day plus clr_month to resynchronise. This covers
//     counters that reset to 0.
//   - Inputs outside SET/RUN events produce no pulses. There are no combinational
//     paths from inputs to outputs.
// STRUCTURE
//   - calendar_pkg holds:
//       state enum {RUN, SET_YEAR, SET_MONTH, SET_DAY}
//       MONTH_FEB=2 and MONTH_DEC=12
//       field_sel encodings
//   - Sub-module dim_lut: pure combinational month/leap -> 5-bit dim.
//     It is shared with the display blocks.
//   - Top holds the FSM, the 2-bit guard counter, the overrun flag and the
//     output registers.
// TESTING
//   - RUN, day=15, month=3, tick:
//       -> inc_day only, 1 cycle after tick.
//   - day=31, month=12, year=42, tick:
//       -> clr_day, clr_month, inc_year in the same cycle.
//   - day=28, month=2: year=24, tick -> inc_day. year=23, tick -> clr_day plus inc_month.
//   - day=31, month=12, year=99, tick:
//       -> clr_day, clr_month, clr_year.
//   - Ticks 1 cycle apart:
//       -> second tick ignored; overrun=1 and held until rst.
//   - mode x3, then SET_DAY with month=2, year=23, day=30, mode:
//       -> clr_day on the RUN entry; field_sel sequence 1,2,3,0.
//   - rst asserted in SET_MONTH the same cycle as inc_btn:
//       -> no pulse; state RUN; field_sel=0.

Source files
------------

// File: rtl/calendar_carry_ctrl_pkg.sv
// calendar_carry_ctrl_pkg
//   Shared types and constants for the century-clock date sequencer:
//   the set-mode state enum, month constants, display field encodings,
//   the guard-window length and a state-to-field helper.
//   No ports (package).

package calendar_carry_ctrl_pkg;

  // Operating state: normal running, or one of the three set-mode fields.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_YEAR  = 2'd1,
    SET_MONTH = 2'd2,
    SET_DAY   = 2'd3
  } state_e;

  localparam logic [3:0] MONTH_FEB = 4'd2;
  localparam logic [3:0] MONTH_DEC = 4'd12;

  // field_sel encodings for the display blink select.
  localparam logic [1:0] FIELD_NONE  = 2'd0;
  localparam logic [1:0] FIELD_YEAR  = 2'd1;
  localparam logic [1:0] FIELD_MONTH = 2'd2;
  localparam logic [1:0] FIELD_DAY   = 2'd3;

  // Number of cycles after an accepted event during which further
  // events are held off so the date counters can settle.
  localparam logic [1:0] GUARD_CYCLES = 2'd2;

  // Maps a state onto the field the display should blink.
  function automatic logic [1:0] field_of(state_e s);
    logic [1:0] f;
    f = FIELD_NONE;
    case (s)
      RUN:       f = FIELD_NONE;
      SET_YEAR:  f = FIELD_YEAR;
      SET_MONTH: f = FIELD_MONTH;
      SET_DAY:   f = FIELD_DAY;
      default:   f = FIELD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/calendar_carry_ctrl_dim_lut.sv
// calendar_carry_ctrl_dim_lut
//   Purely combinational days-in-month lookup, shared with the display
//   blocks. Out-of-range months report 31 so callers see a safe upper bound.
// Ports
//   month_i  in   4  month value (1..12 valid)
//   leap_i   in   1  current year is a leap year
//   dim_o    out  5  days in the month (28..31)

module calendar_carry_ctrl_dim_lut
  import calendar_carry_ctrl_pkg::*;
(
  input  logic [3:0] month_i,
  input  logic       leap_i,
  output logic [4:0] dim_o
);

  // Thirty-day months and February are the exceptions; everything else,
  // including invalid month codes, is 31.
  always_comb begin
    dim_o = 5'd31;
    case (month_i)
      4'd4, 4'd6, 4'd9, 4'd11: dim_o = 5'd30;
      MONTH_FEB:               dim_o = leap_i ? 5'd29 : 5'd28;
      default:                 dim_o = 5'd31;
    endcase
  end

endmodule

// File: rtl/calendar_carry_ctrl.sv
// calendar_carry_ctrl
//   Sequences the day/month/year counters of the century clock. In RUN the
//   end-of-day tick becomes registered increment/clear pulses with month
//   length and leap-year rollover. In set mode the mode button walks
//   year -> month -> day -> run and the inc button steps the selected field.
// Ports
//   clk_i        in   1       system clock
//   rst_i        in   1       synchronous reset, active-high
//   day_tick_i   in   1       end-of-day pulse
//   mode_btn_i   in   1       advance set-mode state
//   inc_btn_i    in   1       step selected field
//   day_i        in   5       current day
//   month_i      in   4       current month
//   year_i       in   YEAR_W  current year
//   inc_day_o .. clr_year_o   out 1  registered one-cycle counter commands
//   field_sel_o  out  2       0 none, 1 year, 2 month, 3 day
//   overrun_o    out  1       sticky: tick arrived inside guard window

module calendar_carry_ctrl
  import calendar_carry_ctrl_pkg::*;
#(
  parameter int YEAR_W   = 7,
  parameter int YEAR_MAX = 99
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              day_tick_i,
  input  logic              mode_btn_i,
  input  logic              inc_btn_i,
  input  logic [4:0]        day_i,
  input  logic [3:0]        month_i,
  input  logic [YEAR_W-1:0] year_i,
  output logic              inc_day_o,
  output logic              clr_day_o,
  output logic              inc_month_o,
  output logic              clr_month_o,
  output logic              inc_year_o,
  output logic              clr_year_o,
  output logic [1:0]        field_sel_o,
  output logic              overrun_o
);

  localparam logic [YEAR_W-1:0] YEAR_MAX_V = YEAR_W'(YEAR_MAX);

  state_e      state_q, state_d;
  logic [1:0]  guard_q;
  logic        overrun_q;
  logic [1:0]  field_sel_q;
  logic        inc_day_q,   inc_day_d;
  logic        clr_day_q,   clr_day_d;
  logic        inc_month_q, inc_month_d;
  logic        clr_month_q, clr_month_d;
  logic        inc_year_q,  inc_year_d;
  logic        clr_year_q,  clr_year_d;
  logic        accept_d;
  logic        overrun_set_d;

  logic [4:0]  dim;
  logic        leap;
  logic        guard_busy;
  logic        date_bad;

  // Year 00 counts as leap, so the two low bits alone decide it.
  assign leap       = (year_i[1:0] == 2'b00);
  assign guard_busy = (guard_q != 2'd0);
  // Counters that came out of reset at zero need resynchronising.
  assign date_bad   = (month_i == 4'd0) || (month_i > MONTH_DEC) || (day_i == 5'd0);

  calendar_carry_ctrl_dim_lut u_dim_lut (
    .month_i (month_i),
    .leap_i  (leap),
    .dim_o   (dim)
  );

  // State, guard counter, sticky overrun and all output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      guard_q     <= 2'd0;
      overrun_q   <= 1'b0;
      field_sel_q <= FIELD_NONE;
      inc_day_q   <= 1'b0;
      clr_day_q   <= 1'b0;
      inc_month_q <= 1'b0;
      clr_month_q <= 1'b0;
      inc_year_q  <= 1'b0;
      clr_year_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      field_sel_q <= field_of(state_d);
      if (accept_d) begin
        guard_q <= GUARD_CYCLES;
      end else if (guard_busy) begin
        guard_q <= guard_q - 2'd1;
      end
      overrun_q   <= overrun_q | overrun_set_d;
      inc_day_q   <= inc_day_d;
      clr_day_q   <= clr_day_d;
      inc_month_q <= inc_month_d;
      clr_month_q <= clr_month_d;
      inc_year_q  <= inc_year_d;
      clr_year_q  <= clr_year_d;
    end
  end

  // Mode button walks the ring RUN -> YEAR -> MONTH -> DAY -> RUN.
  always_comb begin
    state_d = state_q;
    if (mode_btn_i) begin
      case (state_q)
        RUN:       state_d = SET_YEAR;
        SET_YEAR:  state_d = SET_MONTH;
        SET_MONTH: state_d = SET_DAY;
        SET_DAY:   state_d = RUN;
        default:   state_d = RUN;
      endcase
    end
  end

  // Command decode. A mode press always takes priority over an inc press.
  // A day beyond the month length (RUN with an invalid day, or leaving
  // SET_DAY after the month/year was changed) is treated as a rollover.
  always_comb begin
    inc_day_d     = 1'b0;
    clr_day_d     = 1'b0;
    inc_month_d   = 1'b0;
    clr_month_d   = 1'b0;
    inc_year_d    = 1'b0;
    clr_year_d    = 1'b0;
    accept_d      = 1'b0;
    overrun_set_d = 1'b0;
    case (state_q)
      RUN: begin
        if (day_tick_i) begin
          if (guard_busy) begin
            overrun_set_d = 1'b1;
          end else begin
            accept_d = 1'b1;
            if (date_bad) begin
              clr_day_d   = 1'b1;
              clr_month_d = 1'b1;
            end else if (day_i < dim) begin
              inc_day_d = 1'b1;
            end else begin
              clr_day_d = 1'b1;
              if (month_i < MONTH_DEC) begin
                inc_month_d = 1'b1;
              end else begin
                clr_month_d = 1'b1;
                if (year_i >= YEAR_MAX_V) begin
                  clr_year_d = 1'b1;
                end else begin
                  inc_year_d = 1'b1;
                end
              end
            end
          end
        end
      end
      SET_YEAR: begin
        if (inc_btn_i && !mode_btn_i && !guard_busy) begin
          accept_d = 1'b1;
          if (year_i >= YEAR_MAX_V) begin
            clr_year_d = 1'b1;
          end else begin
            inc_year_d = 1'b1;
          end
        end
      end
      SET_MONTH: begin
        if (inc_btn_i && !mode_btn_i && !guard_busy) begin
          accept_d = 1'b1;
          if (month_i >= MONTH_DEC) begin
            clr_month_d = 1'b1;
          end else begin
            inc_month_d = 1'b1;
          end
        end
      end
      SET_DAY: begin
        if (mode_btn_i) begin
          clr_day_d = (day_i > dim);
        end else if (inc_btn_i && !guard_busy) begin
          accept_d = 1'b1;
          if (day_i >= dim) begin
            clr_day_d = 1'b1;
          end else begin
            inc_day_d = 1'b1;
          end
        end
      end
      default: begin
        accept_d = 1'b0;
      end
    endcase
  end

  assign inc_day_o   = inc_day_q;
  assign clr_day_o   = clr_day_q;
  assign inc_month_o = inc_month_q;
  assign clr_month_o = clr_month_q;
  assign inc_year_o  = inc_year_q;
  assign clr_year_o  = clr_year_q;
  assign field_sel_o = field_sel_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_calendar_carry_ctrl.sv
// tb_calendar_carry_ctrl
//   Drives calendar_carry_ctrl with directed calendar scenarios followed by
//   randomized button/tick traffic, and checks every cycle against a
//   behavioural calendar model kept in this file.

module tb_calendar_carry_ctrl;

  logic       clk;
  logic       rst;
  logic       dayTick;
  logic       modeBtn;
  logic       incBtn;
  logic [4:0] dayIn;
  logic [3:0] monthIn;
  logic [6:0] yearIn;
  logic       incDay, clrDay, incMonth, clrMonth, incYear, clrYear;
  logic [1:0] fieldSel;
  logic       overrun;

  int testsRun = 0;
  int testsFailed = 0;

  // Behavioural model state: set-mode index 0..3, cycle counter, cycle of
  // the last accepted event, and the sticky overrun flag.
  int mState = 0;
  int cycleNo = 0;
  int lastAccept = -100;
  bit mOverrun = 1'b0;
  logic [7:0] lastPulses;

  calendar_carry_ctrl #(
    .YEAR_W   (7),
    .YEAR_MAX (99)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .day_tick_i  (dayTick),
    .mode_btn_i  (modeBtn),
    .inc_btn_i   (incBtn),
    .day_i       (dayIn),
    .month_i     (monthIn),
    .year_i      (yearIn),
    .inc_day_o   (incDay),
    .clr_day_o   (clrDay),
    .inc_month_o (incMonth),
    .clr_month_o (clrMonth),
    .inc_year_o  (incYear),
    .clr_year_o  (clrYear),
    .field_sel_o (fieldSel),
    .overrun_o   (overrun)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Days in a month by the Gregorian table; invalid months count as 31.
  function automatic int modelDim(int m, int y);
    int table31[12];
    table31 = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 31;
    if (m == 2 && (y % 4) == 0) return 29;
    return table31[m - 1];
  endfunction

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, predict with the model, then check all
  // outputs shortly after the active edge.
  task automatic applyStimulus(input bit r, input bit t, input bit mo,
                               input bit inb, input int d, input int m,
                               input int y, input string tag);
    bit eIncD, eClrD, eIncM, eClrM, eIncY, eClrY;
    int dim;
    bit open;
    bit bad;
    @(negedge clk);
    rst     = r;
    dayTick = t;
    modeBtn = mo;
    incBtn  = inb;
    dayIn   = 5'(d);
    monthIn = 4'(m);
    yearIn  = 7'(y);
    {eIncD, eClrD, eIncM, eClrM, eIncY, eClrY} = 6'b0;
    dim  = modelDim(m, y);
    open = (cycleNo - lastAccept) > 2;
    bad  = (m < 1) || (m > 12) || (d == 0);
    if (r) begin
      mState     = 0;
      mOverrun   = 1'b0;
      lastAccept = -100;
    end else begin
      if (mState == 0 && t) begin
        if (!open) begin
          mOverrun = 1'b1;
        end else begin
          lastAccept = cycleNo;
          if (bad) begin
            eClrD = 1'b1;
            eClrM = 1'b1;
          end else if (d < dim) begin
            eIncD = 1'b1;
          end else begin
            eClrD = 1'b1;
            if (m < 12) eIncM = 1'b1;
            else begin
              eClrM = 1'b1;
              if (y == 99) eClrY = 1'b1;
              else eIncY = 1'b1;
            end
          end
        end
      end else if (mState == 3 && mo) begin
        eClrD = (d > dim);
      end else if (mState != 0 && inb && !mo && open) begin
        lastAccept = cycleNo;
        if (mState == 1) begin
          if (y == 99) eClrY = 1'b1; else eIncY = 1'b1;
        end else if (mState == 2) begin
          if (m >= 12) eClrM = 1'b1; else eIncM = 1'b1;
        end else begin
          if (d >= dim) eClrD = 1'b1; else eIncD = 1'b1;
        end
      end
      if (mo) mState = (mState + 1) % 4;
    end
    cycleNo++;
    @(posedge clk);
    #1;
    lastPulses = {2'b00, incDay, clrDay, incMonth, clrMonth, incYear, clrYear};
    checkOutput({tag, "_pulses"}, lastPulses,
                {2'b00, eIncD, eClrD, eIncM, eClrM, eIncY, eClrY});
    checkOutput({tag, "_field"}, {6'b0, fieldSel}, 8'(mState));
    checkOutput({tag, "_overrun"}, {7'b0, overrun}, {7'b0, mOverrun});
  endtask

  task automatic idle(input int n, input int d, input int m, input int y);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, d, m, y, "idle");
  endtask

  int rsel, rday, rmon, ryr, rdim, rk;

  initial begin
    rst = 1'b1; dayTick = 1'b0; modeBtn = 1'b0; incBtn = 1'b0;
    dayIn = 5'd1; monthIn = 4'd1; yearIn = 7'd0;

    applyStimulus(1, 0, 0, 0, 1, 1, 0, "reset");
    applyStimulus(1, 0, 0, 0, 1, 1, 0, "reset");
    checkOutput("reset_const", lastPulses, 8'b0);
    idle(2, 15, 3, 10);

    applyStimulus(0, 1, 0, 0, 15, 3, 10, "mar15");
    checkOutput("mar15_const", lastPulses, 8'b0010_0000);
    idle(3, 15, 3, 10);

    applyStimulus(0, 1, 0, 0, 31, 12, 42, "dec31_y42");
    checkOutput("dec31_y42_const", lastPulses, 8'b0001_0110);
    idle(3, 1, 1, 43);

    applyStimulus(0, 1, 0, 0, 28, 2, 24, "feb28_leap");
    checkOutput("feb28_leap_const", lastPulses, 8'b0010_0000);
    idle(3, 28, 2, 23);
    applyStimulus(0, 1, 0, 0, 28, 2, 23, "feb28_noleap");
    checkOutput("feb28_noleap_const", lastPulses, 8'b0001_1000);
    idle(3, 29, 2, 0);
    applyStimulus(0, 1, 0, 0, 29, 2, 0, "feb29_y00");
    idle(3, 31, 12, 99);

    applyStimulus(0, 1, 0, 0, 31, 12, 99, "dec31_y99");
    checkOutput("dec31_y99_const", lastPulses, 8'b0001_0101);
    idle(3, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, "zero_resync");
    checkOutput("zero_resync_const", lastPulses, 8'b0001_0100);
    idle(3, 10, 5, 10);

    // Back-to-back ticks: second lands in the guard window.
    applyStimulus(0, 1, 0, 0, 10, 5, 10, "tick_a");
    applyStimulus(0, 1, 0, 0, 11, 5, 10, "tick_b");
    checkOutput("overrun_set", {7'b0, overrun}, 8'd1);
    idle(5, 11, 5, 10);
    checkOutput("overrun_held", {7'b0, overrun}, 8'd1);
    applyStimulus(1, 0, 0, 0, 11, 5, 10, "rst_ovr");
    checkOutput("overrun_clear", {7'b0, overrun}, 8'd0);
    idle(3, 30, 2, 23);

    // Walk through set mode and leave SET_DAY on an impossible Feb 30.
    applyStimulus(0, 0, 1, 0, 30, 2, 23, "mode1");
    idle(1, 30, 2, 23);
    applyStimulus(0, 1, 0, 0, 30, 2, 23, "set_tick_ignored");
    applyStimulus(0, 0, 1, 0, 30, 2, 23, "mode2");
    idle(1, 30, 2, 23);
    applyStimulus(0, 0, 1, 0, 30, 2, 23, "mode3");
    checkOutput("field_day", {6'b0, fieldSel}, 8'd3);
    idle(1, 30, 2, 23);
    applyStimulus(0, 0, 1, 0, 30, 2, 23, "mode_exit");
    checkOutput("exit_clr_day", lastPulses, 8'b0001_0000);
    checkOutput("exit_field", {6'b0, fieldSel}, 8'd0);
    idle(3, 12, 12, 99);

    // Set-mode stepping at the wrap boundaries, and mode beating inc.
    applyStimulus(0, 0, 1, 0, 12, 12, 99, "to_year");
    idle(3, 12, 12, 99);
    applyStimulus(0, 0, 0, 1, 12, 12, 99, "year_wrap");
    applyStimulus(0, 0, 0, 1, 12, 12, 0, "year_guarded");
    idle(3, 12, 12, 0);
    applyStimulus(0, 0, 1, 1, 12, 12, 0, "mode_beats_inc");
    idle(3, 12, 12, 0);
    applyStimulus(0, 0, 0, 1, 12, 12, 0, "month_wrap");
    idle(3, 12, 1, 0);

    // Reset arriving together with inc in SET_MONTH.
    applyStimulus(1, 0, 0, 1, 12, 1, 0, "rst_in_set");
    checkOutput("rst_in_set_const", lastPulses, 8'b0);
    checkOutput("rst_in_set_field", {6'b0, fieldSel}, 8'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rk   = int'($urandom_range(0, 19));
      rmon = (rk == 0) ? 0 : (rk == 1) ? 13 : int'($urandom_range(1, 12));
      ryr  = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 99));
      rdim = modelDim(rmon, ryr);
      rday = int'($urandom_range(1, rdim));
      rk   = int'($urandom_range(0, 15));
      if (rk == 0) rday = 0;
      else if (rk == 1) rday = rdim;
      else if (rk == 2 && mState != 0 && rdim < 31) rday = rdim + 1;
      rsel = int'($urandom_range(0, 11));
      if ($urandom_range(0, 199) == 0)
        applyStimulus(1, 0, 0, 0, rday, rmon, ryr, "rnd_rst");
      else if (rsel <= 2)
        applyStimulus(0, 1, 0, 0, rday, rmon, ryr, "rnd_tick");
      else if (rsel == 3)
        applyStimulus(0, 0, 1, 0, rday, rmon, ryr, "rnd_mode");
      else if (rsel <= 5)
        applyStimulus(0, 0, 0, 1, rday, rmon, ryr, "rnd_inc");
      else if (rsel == 6)
        applyStimulus(0, 0, 1, 1, rday, rmon, ryr, "rnd_mode_inc");
      else
        applyStimulus(0, 0, 0, 0, rday, rmon, ryr, "rnd_idle");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
